// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, FSM encoding and Set 2 make-code lookup for the PS/2 key emitter
package ps2_pkg;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam int FRAME_BITS = 11;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_LOAD = 2'd1;
  localparam state_t S_TX   = 2'd2;
  localparam state_t S_GAP  = 2'd3;
  // Entry 0 (A) sits in the low byte, entry 25 (Z) in the high byte.
  localparam logic [26*8-1:0] MAKE_TBL = {
    8'h1A, 8'h35, 8'h22, 8'h1D, 8'h2A, 8'h3C, 8'h2C, 8'h1B, 8'h2D, 8'h15, 8'h4D, 8'h44, 8'h31,
    8'h3A, 8'h4B, 8'h42, 8'h3B, 8'h43, 8'h33, 8'h34, 8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C};
  function automatic logic [7:0] ps2_make_code(input logic [4:0] idx);
    return MAKE_TBL[{idx, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/ps2_byte_tx.sv
// ps2_byte_tx: serialises one byte as an 11-bit device-to-host PS/2 frame
module ps2_byte_tx
  import ps2_pkg::*;
#(
  parameter int HALF = 4000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       ps2_clk,
  output logic       ps2_data
);
  localparam int CW = $clog2(2 * HALF);
  logic                  active;
  logic [CW-1:0]         cnt;
  logic [3:0]            slot;
  logic [FRAME_BITS-1:0] sh;
  assign tx_ready = !active;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active   <= 1'b0;
      cnt      <= '0;
      slot     <= '0;
      sh       <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else if (!active) begin
      if (tx_valid) begin
        active   <= 1'b1;
        cnt      <= '0;
        slot     <= '0;
        sh       <= {1'b1, ~^tx_byte, tx_byte, 1'b0};
        ps2_clk  <= 1'b1;
        ps2_data <= 1'b0;
      end
    end else if (cnt == CW'(2 * HALF - 1)) begin
      // Slot boundary: data changes here while the clock is high.
      cnt     <= '0;
      ps2_clk <= 1'b1;
      if (slot == 4'(FRAME_BITS - 1)) begin
        active   <= 1'b0;
        ps2_data <= 1'b1;
      end else begin
        slot     <= slot + 1'b1;
        sh       <= sh >> 1;
        ps2_data <= sh[1];
      end
    end else begin
      cnt     <= cnt + 1'b1;
      ps2_clk <= cnt < CW'(HALF - 1);
    end
  end
endmodule

// File: rtl/ps2_key_emitter.sv
// ps2_key_emitter: turns letter-key level changes into PS/2 Set 2 make/break frames
module ps2_key_emitter
  import ps2_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int PS2_HZ = 12_500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [25:0] key_status,
  output logic        ps2_clk,
  output logic        ps2_data,
  output logic        busy
);
  localparam int HALF = CLK_HZ / (2 * PS2_HZ);
  localparam int GW = $clog2(2 * HALF);
  state_t        state;
  logic [25:0]   key_prev;
  logic [25:0]   diff;
  logic [4:0]    idx;
  logic [7:0]    q0, q1;
  logic [1:0]    q_n;
  logic [GW-1:0] gap;
  logic          gap_end;
  logic          tx_ready;
  assign diff = key_status ^ key_prev;
  always_comb begin
    idx = '0;
    for (int i = 25; i >= 0; i--) if (diff[i]) idx = 5'(i);
  end
  // The TX-done cycle already counts as idle line time, and a following LOAD takes one more.
  assign gap_end = gap == (q_n != 0 ? GW'(2 * HALF - 3) : GW'(2 * HALF - 2));
  ps2_byte_tx #(.HALF(HALF)) u_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_valid (state == S_LOAD),
    .tx_byte  (q0),
    .tx_ready (tx_ready),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      key_prev <= '0;
      q0       <= '0;
      q1       <= '0;
      q_n      <= '0;
      gap      <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (diff != 0) begin
          key_prev[idx] <= key_status[idx];
          q0    <= key_status[idx] ? ps2_make_code(idx) : SC_BREAK;
          q1    <= ps2_make_code(idx);
          q_n   <= key_status[idx] ? 2'd1 : 2'd2;
          state <= S_LOAD;
        end
        S_LOAD: begin
          q0    <= q1;
          q_n   <= q_n - 1'b1;
          busy  <= 1'b1;
          state <= S_TX;
        end
        S_TX: if (tx_ready) begin
          gap   <= '0;
          state <= S_GAP;
        end
        default: if (gap_end) begin
          busy  <= q_n != 0;
          state <= q_n != 0 ? S_LOAD : S_IDLE;
        end else gap <= gap + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_key_emitter.sv
// tb_ps2_key_emitter: scoreboard bench decoding PS/2 frames against a key-event model
module tb_ps2_key_emitter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [25:0] key_status = '0;
  logic        ps2_clk, ps2_data, busy;

  ps2_key_emitter #(.CLK_HZ(800), .PS2_HZ(100)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_status (key_status),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_q[$];
  logic [25:0] model_prev = '0;
  logic [7:0]  mk[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                          8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                          8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  int          nbits = 0;
  logic [10:0] frame = '0;
  logic [10:0] last_frame = '0;
  int          gap_seen = -1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: every changed key becomes one event, lowest index first.
  task automatic apply(input logic [25:0] v);
    for (int i = 0; i < 26; i++)
      if (v[i] != model_prev[i]) begin
        if (!v[i]) exp_q.push_back(8'hF0);
        exp_q.push_back(mk[i]);
      end
    model_prev = v;
    key_status = v;
  endtask

  task automatic settle();
    int quiet = 0, n = 0;
    while (quiet < 4 && n < 20000) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
      n++;
    end
    if (n >= 20000) chk("settle_timeout", n, 0);
  endtask

  task automatic event_check(input string nm, input int exp_len);
    int len = 1;
    @(negedge clk);
    chk({nm, "_load_data"}, ps2_data, 1);
    chk({nm, "_load_busy"}, busy, 0);
    @(negedge clk);
    chk({nm, "_start_data"}, ps2_data, 0);
    chk({nm, "_start_busy"}, busy, 1);
    do begin
      @(negedge clk);
      if (busy) len++;
    end while (busy && len < 5000);
    chk({nm, "_busy_len"}, len, exp_len);
  endtask

  // Monitor: decode frames on falling ps2_clk, check timing, pop the scoreboard.
  int stab = 0, lowc = 0, gapc = 0;
  logic pc = 1'b1, pd = 1'b1, armed = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      nbits = 0; stab = 0; lowc = 0; armed = 1'b0; pc = 1'b1; pd = 1'b1;
    end else begin
      stab = (ps2_data == pd) ? stab + 1 : 1;
      if (armed) begin
        if (ps2_clk && ps2_data) gapc++;
        else if (!ps2_data) begin gap_seen = gapc; armed = 1'b0; end
      end
      if (pc && !ps2_clk) begin
        chk("setup_cycles", stab > 5 ? 5 : stab, 5);
        frame[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          chk("start_bit", frame[0], 0);
          chk("stop_bit", frame[10], 1);
          chk("parity", frame[9], ~^frame[8:1]);
          if (exp_q.size() == 0) chk("extra_frame", int'(frame[8:1]), 256);
          else chk("frame_byte", int'(frame[8:1]), int'(exp_q.pop_front()));
          last_frame = frame;
          nbits = 0; armed = 1'b1; gapc = 0;
        end
      end
      if (!ps2_clk) lowc++;
      if (!pc && ps2_clk) begin chk("low_phase", lowc, 4); lowc = 0; end
      pc = ps2_clk;
      pd = ps2_data;
    end
  end

  initial begin
    int bad = 0, lowc2, len2, n;
    logic [25:0] mask;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("reset_clk", ps2_clk, 1);
    chk("reset_data", ps2_data, 1);
    chk("reset_busy", busy, 0);
    repeat (200) begin
      @(negedge clk);
      if (!(ps2_clk && ps2_data && !busy)) bad++;
    end
    chk("reset_idle", bad, 0);

    @(negedge clk); apply(26'd1 << 22);
    event_check("press_w", 96);
    chk("press_w_bits", last_frame, 11'b11000111010);
    settle();

    @(negedge clk); apply('0);
    event_check("release_w", 192);
    chk("release_gap", gap_seen, 8);
    chk("release_last", int'(last_frame[8:1]), 8'h1D);
    settle();

    @(negedge clk); apply(26'b1001);
    event_check("simul_a", 96);
    chk("simul_a_byte", int'(last_frame[8:1]), 8'h1C);
    lowc2 = 1;
    while (!busy && lowc2 < 100) begin @(negedge clk); if (!busy) lowc2++; end
    chk("simul_idle_between", lowc2, 2);
    len2 = 1;
    do begin @(negedge clk); if (busy) len2++; end while (busy && len2 < 5000);
    chk("simul_d_busy_len", len2, 96);
    chk("simul_d_byte", int'(last_frame[8:1]), 8'h23);
    settle();
    @(negedge clk); apply('0);
    settle();

    @(negedge clk); apply(26'd1 << 18);
    n = 0;
    while (nbits < 5 && n < 2000) begin @(negedge clk); n++; end
    chk("midframe_reached", nbits, 5);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_clk", ps2_clk, 1);
    chk("midreset_data", ps2_data, 1);
    chk("midreset_busy", busy, 0);
    reset_n = 1'b1;
    settle();
    chk("midreset_resend", int'(last_frame[8:1]), 8'h1B);

    for (int it = 0; it < 30; it++) begin
      mask = '0;
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) mask[$urandom_range(0, 25)] = 1'b1;
      @(negedge clk); apply(model_prev ^ mask);
      settle();
    end
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
